// File: rtl/spi_master_scheduler_pkg.sv
// Shared types and constants for the SPI bus scheduler.
// This covers the FSM state encoding, the device map and the chip-select mapping.
package robocup_spi_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DEV_COUNT  = 7;

  localparam int DEV_DRV0 = 0;
  localparam int DEV_DRV1 = 1;
  localparam int DEV_DRV2 = 2;
  localparam int DEV_DRV3 = 3;
  localparam int DEV_DRV4 = 4;
  localparam int DEV_ADC0 = 5;
  localparam int DEV_ADC1 = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_XFER,
    S_HOLD,
    S_GAP
  } sched_state_t;

  // Active-low select vector with only the addressed device pulled low.
  function automatic logic [DEV_COUNT-1:0] dev_ncs_mask(input logic [2:0] idx);
    return ~(DEV_COUNT'(1) << idx);
  endfunction

endpackage

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first set request at or after the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 7,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  input  logic             grant_en,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int j;
    j           = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(pointer) + i) % N;
      if (grant_en && !grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_master_scheduler.sv
// Shares one SPI_Master between the DRV chips and ADCs.
// It handles round-robin grants, chip-select timing, timeout and the response return.
module spi_master_scheduler #(
  parameter int NUM_MOTORS      = 5,
  parameter int NUM_ADCS        = 2,
  parameter int NUM_DEV         = NUM_MOTORS + NUM_ADCS,
  parameter int DATA_WIDTH      = robocup_spi_pkg::DATA_WIDTH,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_IDLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_DEV-1:0]            req,
  input  logic [NUM_DEV*DATA_WIDTH-1:0] req_data,
  output logic [NUM_DEV-1:0]            ack,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic [2:0]                    rsp_dev,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          sched_busy,
  output logic                          spi_start,
  input  logic                          spi_busy,
  input  logic                          spi_valid,
  output logic [DATA_WIDTH-1:0]         spi_tx_data,
  input  logic [DATA_WIDTH-1:0]         spi_rx_data,
  output logic                          spi_sel,
  output logic [NUM_MOTORS-1:0]         drv_ncs,
  output logic [NUM_ADCS-1:0]           adc_ncs
);

  import robocup_spi_pkg::*;

  localparam int IDX_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES)
                           ? ((CS_SETUP_CYCLES > CS_IDLE_CYCLES) ? CS_SETUP_CYCLES : CS_IDLE_CYCLES)
                           : ((CS_HOLD_CYCLES > CS_IDLE_CYCLES) ? CS_HOLD_CYCLES : CS_IDLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t          state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      cur_idx;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  grant_en;
  logic [CNT_W-1:0]      cnt;
  logic [TMO_W-1:0]      tcnt;
  logic [NUM_DEV-1:0]    ncs;
  logic [DEV_COUNT-1:0]  grant_mask;
  logic [DATA_WIDTH-1:0] grant_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign grant_en   = en && !spi_busy && (state == S_IDLE);
  assign grant_mask = dev_ncs_mask(3'(grant_idx));
  assign grant_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  rr_arbiter #(
    .N     (NUM_DEV),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req),
    .pointer     (ptr),
    .grant_en    (grant_en),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cur_idx     <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      ncs         <= '1;
      spi_sel     <= 1'b1;
      spi_start   <= 1'b0;
      ack         <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_dev     <= '0;
      rsp_data    <= '0;
      sched_busy  <= 1'b0;
      spi_tx_data <= '0;
    end else begin
      ack       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            cur_idx     <= grant_idx;
            spi_tx_data <= grant_data;
            ptr         <= (int'(grant_idx) == NUM_DEV - 1) ? '0 : grant_idx + 1'b1;
            ncs         <= grant_mask[NUM_DEV-1:0];
            spi_sel     <= 1'b0;
            cnt         <= '0;
            sched_busy  <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
            cnt       <= '0;
            spi_start <= 1'b1;
            state     <= S_START;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_START: begin
          spi_start <= 1'b0;
          tcnt      <= '0;
          state     <= S_XFER;
        end
        S_XFER: begin
          if (spi_valid) begin
            rsp_data <= spi_rx_data;
            rsp_err  <= 1'b0;
            cnt      <= '0;
            state    <= S_HOLD;
          end else if (tcnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            cnt      <= '0;
            state    <= S_HOLD;
          end else begin
            tcnt <= (tcnt == '1) ? tcnt : tcnt + 1'b1;
          end
        end
        S_HOLD: begin
          // CS release and the response pulse land on the same edge.
          if (cnt == CNT_W'(CS_HOLD_CYCLES - 1)) begin
            ncs       <= '1;
            spi_sel   <= 1'b1;
            ack       <= NUM_DEV'(1) << cur_idx;
            rsp_valid <= 1'b1;
            rsp_dev   <= 3'(cur_idx);
            cnt       <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(CS_IDLE_CYCLES - 1)) begin
            cnt        <= '0;
            sched_busy <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          ncs        <= '1;
          spi_sel    <= 1'b1;
          spi_start  <= 1'b0;
          sched_busy <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign drv_ncs = ncs[NUM_MOTORS-1:0];
  assign adc_ncs = ncs[NUM_DEV-1:NUM_MOTORS];

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Directed bench for spi_master_scheduler with a small SPI_Master response model.
// A negedge monitor records every response frame.
module tb_spi_master_scheduler;

  localparam int NM = 5;
  localparam int NA = 2;
  localparam int ND = 7;
  localparam int DW = 16;

  logic             sysclk = 1'b0;
  logic             rst_n;
  logic             en = 1'b0;
  logic [ND-1:0]    req = '0;
  logic [ND*DW-1:0] req_data = '0;
  logic [ND-1:0]    ack;
  logic             rsp_valid;
  logic             rsp_err;
  logic [2:0]       rsp_dev;
  logic [DW-1:0]    rsp_data;
  logic             sched_busy;
  logic             spi_start;
  logic             spi_busy = 1'b0;
  logic             spi_valid = 1'b0;
  logic [DW-1:0]    spi_tx_data;
  logic [DW-1:0]    spi_rx_data = '0;
  logic             spi_sel;
  logic [NM-1:0]    drv_ncs;
  logic [NA-1:0]    adc_ncs;
  logic [ND-1:0]    ncs_all;

  int            checks = 0;
  int            failures = 0;
  int            valid_delay = 0;
  logic [DW-1:0] rx_word = '0;
  bit            auto_rearm = 1'b0;
  logic [ND-1:0] rearm = '0;

  int resp_n = 0;
  int low_cnt = 0;
  int start_off = -1;
  int hi_cnt = 0;
  int min_gap = 1000;
  int multi_low = 0;
  bit seen_frame = 1'b0;
  logic [31:0] f_drv, f_adc, f_sel, f_tx, f_busy;
  logic [31:0] r_dev[32], r_err[32], r_data[32], r_ack[32], r_low[32], r_start[32];
  logic [31:0] r_drv[32], r_adc[32], r_sel[32], r_tx[32], r_busy[32];

  assign ncs_all = {adc_ncs, drv_ncs};

  spi_master_scheduler dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_dev     (rsp_dev),
    .rsp_data    (rsp_data),
    .sched_busy  (sched_busy),
    .spi_start   (spi_start),
    .spi_busy    (spi_busy),
    .spi_valid   (spi_valid),
    .spi_tx_data (spi_tx_data),
    .spi_rx_data (spi_rx_data),
    .spi_sel     (spi_sel),
    .drv_ncs     (drv_ncs),
    .adc_ncs     (adc_ncs)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input string tag, input int n, input int budget);
    int k = 0;
    while (resp_n < n && k < budget) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    check_val(tag, 32'(resp_n >= n), 32'd1);
  endtask

  // SPI_Master stand-in: VALID arrives valid_delay cycles after START; 0 means never.
  initial begin : spi_model
    forever begin
      @(negedge sysclk);
      if (spi_start && valid_delay > 0) begin
        repeat (valid_delay) @(posedge sysclk);
        #1;
        spi_valid   = 1'b1;
        spi_rx_data = rx_word;
        @(posedge sysclk);
        #1;
        spi_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge sysclk);
      if ($countones(~ncs_all) > 1) multi_low++;
      if (!rst_n) begin
        low_cnt    = 0;
        start_off  = -1;
        hi_cnt     = 0;
        seen_frame = 1'b0;
      end else if (ncs_all != '1) begin
        if (low_cnt == 0) begin
          if (seen_frame && hi_cnt < min_gap) min_gap = hi_cnt;
          f_drv  = 32'(drv_ncs);
          f_adc  = 32'(adc_ncs);
          f_sel  = 32'(spi_sel);
          f_tx   = 32'(spi_tx_data);
          f_busy = 32'(sched_busy);
        end
        if (spi_start && start_off < 0) start_off = low_cnt;
        low_cnt++;
        hi_cnt = 0;
      end else begin
        hi_cnt++;
      end
      if (rsp_valid && resp_n < 32) begin
        r_dev[resp_n]   = 32'(rsp_dev);
        r_err[resp_n]   = 32'(rsp_err);
        r_data[resp_n]  = 32'(rsp_data);
        r_ack[resp_n]   = 32'(ack);
        r_low[resp_n]   = low_cnt;
        r_start[resp_n] = start_off;
        r_drv[resp_n]   = f_drv;
        r_adc[resp_n]   = f_adc;
        r_sel[resp_n]   = f_sel;
        r_tx[resp_n]    = f_tx;
        r_busy[resp_n]  = f_busy;
        resp_n++;
        low_cnt    = 0;
        start_off  = -1;
        seen_frame = 1'b1;
      end
      req   = (req & ~ack) | (auto_rearm ? rearm : '0);
      rearm = ack;
    end
  end

  initial begin : stim
    int base;
    int act;
    int k;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    check_val("rst_drv_ncs", 32'(drv_ncs), 32'h1f);
    check_val("rst_adc_ncs", 32'(adc_ncs), 32'h3);
    check_val("rst_spi_sel", 32'(spi_sel), 32'h1);
    check_val("rst_spi_start", 32'(spi_start), 32'h0);
    check_val("rst_ack", 32'(ack), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'h0);
    check_val("rst_busy", 32'(sched_busy), 32'h0);
    check_val("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_val("rst_rsp_dev", 32'(rsp_dev), 32'h0);
    check_val("rst_tx_data", 32'(spi_tx_data), 32'h0);
    @(posedge sysclk);
    #3 rst_n = 1'b1;
    en = 1'b1;

    // All seven requesters held: strict round-robin from pointer 0.
    @(posedge sysclk);
    #1;
    base        = resp_n;
    valid_delay = 3;
    rx_word     = 16'h1111;
    for (int d = 0; d < ND; d++) req_data[d*DW +: DW] = DW'(16'hA000 + d);
    auto_rearm = 1'b1;
    req        = '1;
    wait_resp("rr_wait", base + 8, 400);
    auto_rearm = 1'b0;
    req        = '0;
    for (int i = 0; i < 8; i++) check_val($sformatf("rr_order_%0d", i), r_dev[base+i], 32'(i % ND));
    check_val("rr_tx_dev4", r_tx[base+4], 32'hA004);
    check_val("rr_low_cycles", r_low[base], 32'd8);
    check_val("rr_min_gap_ge4", 32'(min_gap >= 4), 32'd1);
    check_val("rr_single_cs", 32'(multi_low), 32'd0);

    // Single DRV request with a 40-cycle SPI transfer.
    repeat (10) @(posedge sysclk);
    #1;
    base                 = resp_n;
    valid_delay          = 40;
    rx_word              = 16'hBEEF;
    req_data[2*DW +: DW] = 16'h1234;
    req[2]               = 1'b1;
    wait_resp("single_wait", base + 1, 200);
    check_val("single_drv_ncs", r_drv[base], 32'h1b);
    check_val("single_adc_ncs", r_adc[base], 32'h3);
    check_val("single_spi_sel", r_sel[base], 32'h0);
    check_val("single_busy", r_busy[base], 32'h1);
    check_val("single_start_offset", r_start[base], 32'd2);
    check_val("single_tx_data", r_tx[base], 32'h1234);
    check_val("single_low_cycles", r_low[base], 32'd45);
    check_val("single_ack", r_ack[base], 32'h04);
    check_val("single_dev", r_dev[base], 32'd2);
    check_val("single_rx_data", r_data[base], 32'hBEEF);
    check_val("single_err", r_err[base], 32'd0);

    // ADC mapping.
    repeat (10) @(posedge sysclk);
    #1;
    base        = resp_n;
    valid_delay = 5;
    rx_word     = 16'h0A0C;
    req[6]      = 1'b1;
    wait_resp("adc_wait", base + 1, 100);
    check_val("adc_adc_ncs", r_adc[base], 32'h1);
    check_val("adc_drv_ncs", r_drv[base], 32'h1f);
    check_val("adc_dev", r_dev[base], 32'd6);
    check_val("adc_ack", r_ack[base], 32'h40);
    check_val("adc_rx_data", r_data[base], 32'h0A0C);

    // Timeout, then a normal frame.
    repeat (10) @(posedge sysclk);
    #1;
    base        = resp_n;
    valid_delay = 0;
    req[4]      = 1'b1;
    wait_resp("tmo_wait", base + 1, 1200);
    check_val("tmo_err", r_err[base], 32'd1);
    check_val("tmo_data", r_data[base], 32'h0);
    check_val("tmo_dev", r_dev[base], 32'd4);
    check_val("tmo_low_cycles", r_low[base], 32'd1029);
    valid_delay = 7;
    rx_word     = 16'h5A5A;
    @(posedge sysclk);
    #1;
    req[5] = 1'b1;
    wait_resp("post_tmo_wait", base + 2, 100);
    check_val("post_tmo_err", r_err[base+1], 32'd0);
    check_val("post_tmo_data", r_data[base+1], 32'h5A5A);
    check_val("post_tmo_dev", r_dev[base+1], 32'd5);
    check_val("post_tmo_low", r_low[base+1], 32'd12);

    // Enable gating, and en falling mid-frame.
    repeat (10) @(posedge sysclk);
    #1;
    base        = resp_n;
    valid_delay = 4;
    rx_word     = 16'h0042;
    en          = 1'b0;
    req[1]      = 1'b1;
    act         = 0;
    repeat (100) begin
      @(negedge sysclk);
      if (ncs_all != '1 || sched_busy) act++;
    end
    check_val("en0_no_activity", act, 32'd0);
    @(posedge sysclk);
    #1 en = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    check_val("en1_grant_dev1", 32'(drv_ncs), 32'h1d);
    en = 1'b0;
    wait_resp("en_mid_wait", base + 1, 100);
    check_val("en_mid_dev", r_dev[base], 32'd1);
    req[0] = 1'b1;
    act    = 0;
    repeat (30) begin
      @(negedge sysclk);
      if (ncs_all != '1) act++;
    end
    check_val("en_mid_no_regrant", act, 32'd0);
    @(posedge sysclk);
    #1 en = 1'b1;
    wait_resp("en_resume_wait", base + 2, 100);
    check_val("en_resume_dev", r_dev[base+1], 32'd0);

    // Reset in XFER on device 3, then pointer restarts at 0.
    repeat (10) @(posedge sysclk);
    #1;
    valid_delay = 0;
    req[3]      = 1'b1;
    k           = 0;
    while (drv_ncs != 5'h17 && k < 50) begin
      @(negedge sysclk);
      k++;
    end
    check_val("rst_frame_started", 32'(drv_ncs), 32'h17);
    repeat (20) @(negedge sysclk);
    base = resp_n;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid_drv_ncs", 32'(drv_ncs), 32'h1f);
    check_val("rst_mid_spi_sel", 32'(spi_sel), 32'h1);
    check_val("rst_mid_spi_start", 32'(spi_start), 32'h0);
    check_val("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    req[0]      = 1'b1;
    valid_delay = 4;
    rx_word     = 16'h0303;
    repeat (3) @(posedge sysclk);
    #3 rst_n = 1'b1;
    wait_resp("rst_after_wait", base + 2, 100);
    check_val("rst_after_first", r_dev[base], 32'd0);
    check_val("rst_after_second", r_dev[base+1], 32'd3);
    check_val("rst_after_ack3", r_ack[base+1], 32'h08);

    // Reset while START is high.
    repeat (10) @(posedge sysclk);
    #1;
    valid_delay = 0;
    req[2]      = 1'b1;
    k           = 0;
    @(negedge sysclk);
    while (!spi_start && k < 50) begin
      @(negedge sysclk);
      k++;
    end
    check_val("start_seen", 32'(spi_start), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_start_forced", 32'(spi_start), 32'h0);
    check_val("rst_start_drv_ncs", 32'(drv_ncs), 32'h1f);
    req = '0;
    repeat (2) @(posedge sysclk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge sysclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
